// File: rtl/ahbl_sram_ctrl_if.sv
// AHB-Lite slave-side bus bundle for ahbl_sram_ctrl.
// Carries the address/control/write-data signals from the master and the
// read-data/ready/response signals back from the slave.
//   master modport: drives hsel, haddr, hburst, hmastlock, hprot, hsize,
//                   htrans, hwdata, hwrite; samples hrdata, hready, hresp
//   slave modport : the mirror image
interface ahbl_sram_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  ahbl_hsel;
    logic [ADDR_WIDTH-1:0] ahbl_haddr;
    logic [2:0]            ahbl_hburst;
    logic                  ahbl_hmastlock;
    logic [3:0]            ahbl_hprot;
    logic [2:0]            ahbl_hsize;
    logic [1:0]            ahbl_htrans;
    logic [DATA_WIDTH-1:0] ahbl_hwdata;
    logic                  ahbl_hwrite;
    logic [DATA_WIDTH-1:0] ahbl_hrdata;
    logic                  ahbl_hready;
    logic                  ahbl_hresp;

    modport master (
        output ahbl_hsel, ahbl_haddr, ahbl_hburst, ahbl_hmastlock, ahbl_hprot,
               ahbl_hsize, ahbl_htrans, ahbl_hwdata, ahbl_hwrite,
        input  ahbl_hrdata, ahbl_hready, ahbl_hresp
    );

    modport slave (
        input  ahbl_hsel, ahbl_haddr, ahbl_hburst, ahbl_hmastlock, ahbl_hprot,
               ahbl_hsize, ahbl_htrans, ahbl_hwdata, ahbl_hwrite,
        output ahbl_hrdata, ahbl_hready, ahbl_hresp
    );
endinterface

// File: rtl/ahbl_sram_ctrl.sv
// AHB-Lite slave in front of a byte-laned single-port SRAM array.
// Adds programmable wait states, two-cycle ERROR responses for out-of-range,
// oversized or misaligned transfers, and write-to-read forwarding so a read
// accepted on the edge a write commits sees the new bytes.
// Ports:
//   clk  - rising-edge clock
//   rstn - asynchronous active-low reset (array contents are not reset)
//   ahbl - AHB-Lite slave bundle (hsel/haddr/hsize/htrans/hwrite/hwdata in,
//          hrdata/hready/hresp out; hburst/hmastlock/hprot are ignored)
module ahbl_sram_ctrl #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_BYTES   = 16384,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input logic             clk,
    input logic             rstn,
    ahbl_sram_ctrl_if.slave ahbl
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(NB);
    localparam int DEPTH = MEM_BYTES / NB;
    localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);
    localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_e;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  dp_wr_q, dp_wr_d;
    logic                  dp_rd_q, dp_rd_d;
    logic [IDXW-1:0]       dp_idx_q, dp_idx_d;
    logic [NB-1:0]         dp_strb_q, dp_strb_d;
    logic [DATA_WIDTH-1:0] rdbuf_q, rdbuf_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  hready, hresp, accept, legal, commit;
    logic [ADDR_WIDTH-1:0] off;
    logic [IDXW-1:0]       idx;
    logic [NB-1:0]         strb;
    logic [31:0]           lsb_u, sz_u;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_inputs;

    assign unused_inputs = ^{ahbl.ahbl_hburst, ahbl.ahbl_hmastlock, ahbl.ahbl_hprot,
                             ahbl.ahbl_htrans[0]};

    // Outputs decode from registered state only.
    assign hready = (state_q != S_WAIT) && (state_q != S_ERR1);
    assign hresp  = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign ahbl.ahbl_hready = hready;
    assign ahbl.ahbl_hresp  = hresp;
    assign ahbl.ahbl_hrdata = hrdata_q;

    assign accept = ahbl.ahbl_hsel && ahbl.ahbl_htrans[1] && hready;
    // A pending write's data phase ends on any hready-high edge.
    assign commit = dp_wr_q && hready;

    // Address-phase decode. Subtracting the base makes below-base addresses
    // wrap to large offsets, so one compare covers both range limits.
    always_comb begin
        off   = ahbl.ahbl_haddr - BASE_ADDR;
        idx   = off[LSB +: IDXW];
        lsb_u = 32'(ahbl.ahbl_haddr[LSB-1:0]);
        sz_u  = 32'd1 << ahbl.ahbl_hsize;
        legal = ({1'b0, off} < MEM_LIMIT) &&
                (ahbl.ahbl_hsize <= 3'(LSB)) &&
                ((lsb_u & (sz_u - 32'd1)) == 32'd0);
        strb  = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            strb[k] = (k >= lsb_u) && (k < lsb_u + sz_u);
        end
    end

    // Array read at the accept edge, with the committing write merged in.
    always_comb begin
        rd_word = mem_q[idx];
        if (commit && (dp_idx_q == idx)) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (dp_strb_q[k]) rd_word[8*k +: 8] = ahbl.ahbl_hwdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dp_wr_d   = dp_wr_q;
        dp_rd_d   = dp_rd_q;
        dp_idx_d  = dp_idx_q;
        dp_strb_d = dp_strb_q;
        rdbuf_d   = rdbuf_q;
        hrdata_d  = hrdata_q;
        unique case (state_q)
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_DONE;
                    if (dp_rd_q) hrdata_d = rdbuf_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // IDLE, DONE and ERR2 all have hready high: open a new data phase.
                state_d   = S_IDLE;
                dp_wr_d   = accept && legal && ahbl.ahbl_hwrite;
                dp_rd_d   = accept && legal && !ahbl.ahbl_hwrite;
                dp_idx_d  = idx;
                dp_strb_d = strb;
                if (accept) begin
                    if (!legal) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                    // Zero-wait reads present data right after the accept edge;
                    // otherwise park it so hrdata holds the previous read.
                    if (legal && !ahbl.ahbl_hwrite) begin
                        if (WAIT_STATES == 0) hrdata_d = rd_word;
                        else                  rdbuf_d  = rd_word;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dp_wr_q   <= 1'b0;
            dp_rd_q   <= 1'b0;
            dp_idx_q  <= '0;
            dp_strb_q <= '0;
            rdbuf_q   <= '0;
            hrdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dp_wr_q   <= dp_wr_d;
            dp_rd_q   <= dp_rd_d;
            dp_idx_q  <= dp_idx_d;
            dp_strb_q <= dp_strb_d;
            rdbuf_q   <= rdbuf_d;
            hrdata_q  <= hrdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (dp_strb_q[k]) mem_q[dp_idx_q][8*k +: 8] <= ahbl.ahbl_hwdata[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ahbl_sram_ctrl.sv
// Testbench for ahbl_sram_ctrl: two instances (32-bit zero-wait at base 0,
// 64-bit three-wait at base 0x400), driven one at a time by a pipelined
// AHB-Lite master. Expected values come from a byte-array model of the memory.
module tb_ahbl_sram_ctrl;
    localparam logic [31:0] BASE1 = 32'h0000_0400;
    localparam int          MEMB  = 256;

    typedef struct {
        bit          sel;
        logic [1:0]  ht;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        bit          exp_err;
        logic [63:0] exp_rd;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int          cur = 0;
    bit          d_hsel = 1'b0;
    logic [1:0]  d_htrans = 2'b00;
    bit          d_hwrite = 1'b0;
    logic [31:0] d_haddr = '0;
    logic [2:0]  d_hsize = '0;
    logic [63:0] d_hwdata = '0;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] last_rd [2];
    int          ws_of [2] = '{0, 3};
    logic [7:0]  mm [2][MEMB];

    ahbl_sram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    ahbl_sram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus1 ();

    assign bus0.ahbl_hsel      = d_hsel && (cur == 0);
    assign bus0.ahbl_haddr     = d_haddr;
    assign bus0.ahbl_hburst    = 3'b000;
    assign bus0.ahbl_hmastlock = 1'b0;
    assign bus0.ahbl_hprot     = 4'b0011;
    assign bus0.ahbl_hsize     = d_hsize;
    assign bus0.ahbl_htrans    = d_htrans;
    assign bus0.ahbl_hwdata    = d_hwdata[31:0];
    assign bus0.ahbl_hwrite    = d_hwrite;

    assign bus1.ahbl_hsel      = d_hsel && (cur == 1);
    assign bus1.ahbl_haddr     = d_haddr;
    assign bus1.ahbl_hburst    = 3'b000;
    assign bus1.ahbl_hmastlock = 1'b0;
    assign bus1.ahbl_hprot     = 4'b0011;
    assign bus1.ahbl_hsize     = d_hsize;
    assign bus1.ahbl_htrans    = d_htrans;
    assign bus1.ahbl_hwdata    = d_hwdata;
    assign bus1.ahbl_hwrite    = d_hwrite;

    logic        s_hready, s_hresp;
    logic [63:0] s_hrdata;
    assign s_hready = (cur == 1) ? bus1.ahbl_hready : bus0.ahbl_hready;
    assign s_hresp  = (cur == 1) ? bus1.ahbl_hresp  : bus0.ahbl_hresp;
    assign s_hrdata = (cur == 1) ? bus1.ahbl_hrdata : {32'h0, bus0.ahbl_hrdata};

    ahbl_sram_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(MEMB),
        .BASE_ADDR(32'h0), .WAIT_STATES(0)
    ) u_dut0 (.clk(clk), .rstn(rstn), .ahbl(bus0.slave));

    ahbl_sram_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_BYTES(MEMB),
        .BASE_ADDR(BASE1), .WAIT_STATES(3)
    ) u_dut1 (.clk(clk), .rstn(rstn), .ahbl(bus1.slave));

    task automatic finish_bench();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit sel, input logic [1:0] ht, input bit wr,
                                input logic [31:0] a, input logic [2:0] sz,
                                input logic [63:0] wd, input bit err,
                                input logic [63:0] rd, input string nm);
        vec_t v;
        v.sel = sel; v.ht = ht; v.wr = wr; v.addr = a; v.size = sz;
        v.wdata = wd; v.exp_err = err; v.exp_rd = rd; v.name = nm;
        return v;
    endfunction

    // Memory as a flat byte array; transfers take effect in issue order.
    function automatic vec_t model(input int d, input vec_t vin);
        vec_t        v = vin;
        int          nb = (d == 1) ? 8 : 4;
        int          lg = (d == 1) ? 3 : 2;
        logic [31:0] base = (d == 1) ? BASE1 : 32'h0;
        logic [31:0] off, w, lo, n;
        logic [63:0] rd = '0;
        if (!(v.sel && v.ht[1])) return v;
        off = v.addr - base;
        v.exp_err = (off >= MEMB) || (int'(v.size) > lg) ||
                    ((v.addr & ((32'd1 << v.size) - 32'd1)) != 0);
        if (v.exp_err) return v;
        w  = off - (off % nb);
        lo = off % nb;
        n  = 32'd1 << v.size;
        if (v.wr) begin
            for (int k = 0; k < nb; k++)
                if (k >= lo && k < lo + n) mm[d][w + k] = v.wdata[8*k +: 8];
        end else begin
            for (int k = 0; k < nb; k++) rd[8*k +: 8] = mm[d][w + k];
            v.exp_rd = rd;
        end
        return v;
    endfunction

    function automatic vec_t rnd(input int d);
        vec_t        v;
        int          lg = (d == 1) ? 3 : 2;
        logic [31:0] base = (d == 1) ? BASE1 : 32'h0;
        int          r = $urandom_range(0, 19);
        v.name = "rnd"; v.exp_err = 1'b0; v.exp_rd = '0;
        v.sel  = (r != 0);
        v.ht   = (r == 1) ? 2'b00 : (r == 2) ? 2'b01 : (r[0] ? 2'b10 : 2'b11);
        v.wr   = 1'($urandom_range(0, 1));
        v.size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, lg));
        v.addr = base + $urandom_range(0, MEMB - 1);
        if ($urandom_range(0, 7) != 0) v.addr &= ~((32'd1 << v.size) - 32'd1);
        if ($urandom_range(0, 19) == 0)
            v.addr = ($urandom_range(0, 1) == 1) ? base + MEMB + $urandom_range(0, 64)
                                                 : base - 32'($urandom_range(1, 64));
        v.wdata = {$urandom, $urandom};
        return model(d, v);
    endfunction

    // Pipelined master: address phase of vs[i] overlaps data phase of vs[i-1].
    // Each data phase is checked at the negedge where hready is high.
    task automatic run_q(input int d, input vec_t vs[$]);
        vec_t  pv;
        bit    pv_ok = 1'b0;
        bit    xf, perr;
        int    lows;
        string nm;
        cur = d;
        for (int i = 0; i <= vs.size(); i++) begin
            if (i < vs.size()) begin
                d_hsel = vs[i].sel; d_htrans = vs[i].ht; d_hwrite = vs[i].wr;
                d_haddr = vs[i].addr; d_hsize = vs[i].size;
            end else begin
                d_hsel = 1'b0; d_htrans = 2'b00; d_hwrite = 1'b0;
            end
            d_hwdata = pv_ok ? pv.wdata : '0;
            xf   = pv_ok && pv.sel && pv.ht[1];
            perr = xf && pv.exp_err;
            nm   = pv_ok ? $sformatf("dut%0d %s @%h", d, pv.name, pv.addr) : $sformatf("dut%0d idle", d);
            lows = 0;
            forever begin
                @(negedge clk);
                if (s_hready) break;
                lows++;
                chk({nm, " hresp_low"}, 64'(s_hresp), 64'(perr));
                if (lows > 12) begin
                    errors++; checks++;
                    $display("FAIL %s hready_timeout: got low for %0d cycles expected at most %0d", nm, lows, ws_of[d]);
                    finish_bench();
                end
            end
            chk({nm, " wait_cycles"}, 64'(lows), xf ? (perr ? 64'd1 : 64'(ws_of[d])) : 64'd0);
            chk({nm, " hresp"}, 64'(s_hresp), 64'(perr));
            if (xf && !perr && !pv.wr) last_rd[d] = pv.exp_rd;
            chk({nm, " hrdata"}, s_hrdata, last_rd[d]);
            @(posedge clk); #1;
            pv_ok = (i < vs.size());
            if (pv_ok) pv = vs[i];
        end
    endtask

    task automatic preload(input int d);
        vec_t        q[$];
        int          nb = (d == 1) ? 8 : 4;
        logic [31:0] base = (d == 1) ? BASE1 : 32'h0;
        for (int w = 0; w < MEMB / nb; w++)
            q.push_back(model(d, mk(1, 2'b10, 1, base + 32'(w * nb), (d == 1) ? 3'd3 : 3'd2,
                                    {$urandom, $urandom}, 0, '0, "preload")));
        run_q(d, q);
    endtask

    task automatic run_table(input int d, input vec_t tbl[$]);
        vec_t q[$];
        vec_t m;
        for (int i = 0; i < tbl.size(); i++) begin
            m = model(d, tbl[i]);   // keeps the byte model in step; table holds the expectation
            q.push_back(tbl[i]);
        end
        run_q(d, q);
    endtask

    task automatic run_random(input int d, input int n);
        vec_t q[$];
        for (int i = 0; i < n; i++) q.push_back(rnd(d));
        run_q(d, q);
    endtask

    initial begin
        vec_t t0[$];
        vec_t t1[$];
        vec_t q[$];

        // sel, htrans, wr, addr, size, wdata, exp_err, exp_rdata, name
        t0.push_back(mk(1, 2'b10, 1, 32'h10,  3'd2, 64'hDEADBEEF, 0, '0, "w_word"));
        t0.push_back(mk(1, 2'b10, 0, 32'h10,  3'd2, '0,           0, 64'hDEADBEEF, "r_word"));
        t0.push_back(mk(1, 2'b10, 1, 32'h20,  3'd2, 64'h12345678, 0, '0, "w_fwd_base"));
        t0.push_back(mk(1, 2'b11, 1, 32'h21,  3'd0, 64'h0000AA00, 0, '0, "w_byte"));
        t0.push_back(mk(1, 2'b11, 0, 32'h20,  3'd2, '0,           0, 64'h1234AA78, "r_fwd"));
        t0.push_back(mk(1, 2'b10, 1, 32'h0,   3'd2, 64'hCAFEF00D, 0, '0, "w_zero"));
        t0.push_back(mk(1, 2'b10, 1, 32'h100, 3'd2, 64'hFFFFFFFF, 1, '0, "e_range"));
        t0.push_back(mk(1, 2'b10, 1, 32'h1,   3'd1, 64'hFFFFFFFF, 1, '0, "e_align"));
        t0.push_back(mk(1, 2'b10, 1, 32'h0,   3'd3, 64'hFFFFFFFF, 1, '0, "e_size"));
        t0.push_back(mk(1, 2'b10, 0, 32'h0,   3'd2, '0,           0, 64'hCAFEF00D, "r_after_err0"));
        t0.push_back(mk(1, 2'b10, 0, 32'h1,   3'd0, '0,           0, 64'hCAFEF00D, "r_after_err1"));
        t0.push_back(mk(1, 2'b10, 0, 32'h22,  3'd1, '0,           0, 64'h1234AA78, "r_half"));
        t0.push_back(mk(1, 2'b00, 1, 32'h0,   3'd2, 64'h0,        0, '0, "idle"));
        t0.push_back(mk(1, 2'b01, 1, 32'h0,   3'd2, 64'h0,        0, '0, "busy"));
        t0.push_back(mk(0, 2'b10, 1, 32'h0,   3'd2, 64'h0,        0, '0, "unsel"));
        t0.push_back(mk(1, 2'b10, 0, 32'h0,   3'd2, '0,           0, 64'hCAFEF00D, "r_after_unsel"));

        t1.push_back(mk(1, 2'b10, 1, 32'h400, 3'd3, 64'h1122334455667788, 0, '0, "w_dword"));
        t1.push_back(mk(1, 2'b10, 1, 32'h406, 3'd1, 64'hBEEF000000000000, 0, '0, "w_half"));
        t1.push_back(mk(1, 2'b10, 0, 32'h400, 3'd3, '0, 0, 64'hBEEF334455667788, "r_dword"));
        t1.push_back(mk(1, 2'b10, 1, 32'h500, 3'd3, 64'hFFFFFFFFFFFFFFFF, 1, '0, "e_above"));
        t1.push_back(mk(1, 2'b10, 1, 32'h3F8, 3'd3, 64'hFFFFFFFFFFFFFFFF, 1, '0, "e_below"));
        t1.push_back(mk(1, 2'b10, 1, 32'h404, 3'd3, 64'hFFFFFFFFFFFFFFFF, 1, '0, "e_align"));
        t1.push_back(mk(1, 2'b10, 0, 32'h400, 3'd4, '0, 1, '0, "e_size"));
        t1.push_back(mk(1, 2'b10, 0, 32'h407, 3'd0, '0, 0, 64'hBEEF334455667788, "r_byte"));
        t1.push_back(mk(1, 2'b10, 1, 32'h408, 3'd3, 64'h0F0F0F0F0F0F0F0F, 0, '0, "w_dword2"));
        t1.push_back(mk(1, 2'b10, 1, 32'h40C, 3'd2, 64'hA5A5A5A500000000, 0, '0, "w_upper"));
        t1.push_back(mk(1, 2'b10, 0, 32'h408, 3'd3, '0, 0, 64'hA5A5A5A50F0F0F0F, "r_fwd"));

        last_rd[0] = '0;
        last_rd[1] = '0;
        for (int d = 0; d < 2; d++)
            for (int b = 0; b < MEMB; b++) mm[d][b] = '0;

        #1;
        chk("reset dut0 hready", 64'(bus0.ahbl_hready), 64'd1);
        chk("reset dut0 hresp",  64'(bus0.ahbl_hresp),  64'd0);
        chk("reset dut0 hrdata", {32'h0, bus0.ahbl_hrdata}, 64'd0);
        chk("reset dut1 hready", 64'(bus1.ahbl_hready), 64'd1);
        chk("reset dut1 hresp",  64'(bus1.ahbl_hresp),  64'd0);
        chk("reset dut1 hrdata", bus1.ahbl_hrdata, 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        preload(0);
        run_table(0, t0);
        run_random(0, 200);

        preload(1);
        run_table(1, t1);

        // Reset during the wait states of a write to 0x408: must not commit.
        cur = 1;
        d_hsel = 1'b1; d_htrans = 2'b10; d_hwrite = 1'b1; d_haddr = 32'h408; d_hsize = 3'd3;
        @(posedge clk); #1;
        d_hsel = 1'b0; d_htrans = 2'b00; d_hwrite = 1'b0;
        d_hwdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        chk("midrst hready_wait", 64'(s_hready), 64'd0);
        rstn = 1'b0;
        #1;
        chk("midrst hready", 64'(s_hready), 64'd1);
        chk("midrst hresp",  64'(s_hresp),  64'd0);
        chk("midrst hrdata", s_hrdata, 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(posedge clk); #1;
        q.push_back(mk(1, 2'b10, 0, 32'h408, 3'd3, '0, 0, 64'hA5A5A5A50F0F0F0F, "r_after_midrst"));
        run_table(1, q);

        run_random(1, 200);

        finish_bench();
    end
endmodule
